// File: rtl/mac_accumulator.sv
// mac_accumulator: signed multiply-accumulate block with a valid/ready handshake
// on both sides.
//
// Operand pairs are taken on in_valid & in_ready. Each pair is multiplied by
// signed_multiplier and added into a saturating accumulator one cycle after it
// is taken. The term flagged with `last` closes the sum. The block then raises
// out_valid and holds result/count/overflow until the consumer takes them.
//
// Ports (mac_accumulator):
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   in_valid   in   operand pair present
//   in_ready   out  block can accept an operand pair (depends only on state)
//   input0     in   [width]      signed multiplicand
//   input1     in   [width]      signed multiplier
//   last       in   final term of the sum (qualified by in_valid)
//   out_valid  out  result available (HOLD state only)
//   out_ready  in   consumer accepts the result
//   result     out  [acc_width]  signed saturated sum of products (register)
//   count      out  [count_width] number of accumulated terms (saturating)
//   overflow   out  sticky saturation flag for the current sum
//
// Ports (signed_multiplier):
//   a, b       in   [width]      signed operands
//   product    out  [2*width]    signed product

module signed_multiplier #(
    parameter int width = 8
) (
    input  logic signed [width-1:0]   a,
    input  logic signed [width-1:0]   b,
    output logic signed [2*width-1:0] product
);

    assign product = a * b;

endmodule

module mac_accumulator #(
    parameter int width       = 8,
    parameter int acc_width   = 2*width+4,
    parameter int count_width = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [width-1:0]       input0,
    input  logic [width-1:0]       input1,
    input  logic                   last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [acc_width-1:0]   result,
    output logic [count_width-1:0] count,
    output logic                   overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [acc_width-1:0]   acc_max   = {1'b0, {(acc_width-1){1'b1}}};
    localparam logic [acc_width-1:0]   acc_min   = {1'b1, {(acc_width-1){1'b0}}};
    localparam logic [count_width-1:0] count_max = {count_width{1'b1}};
    localparam logic [count_width-1:0] count_one = {{(count_width-1){1'b0}}, 1'b1};

    // Signed add with clamping. Bit [acc_width] of the return value flags that
    // a clamp happened; the lower bits hold the (possibly clamped) sum.
    function automatic logic [acc_width:0] sat_add(
        input logic [acc_width-1:0] a,
        input logic [acc_width-1:0] b
    );
        logic [acc_width:0] sum;
        sum = {a[acc_width-1], a} + {b[acc_width-1], b};
        if (sum[acc_width] != sum[acc_width-1]) begin
            if (sum[acc_width]) begin
                sat_add = {1'b1, acc_min};
            end else begin
                sat_add = {1'b1, acc_max};
            end
        end else begin
            sat_add = {1'b0, sum[acc_width-1:0]};
        end
    endfunction

    state_t                   state_r;
    state_t                   state_next_s;
    logic                     xfer_s;
    logic                     res_xfer_s;

    logic signed [width-1:0]  op0_r;
    logic signed [width-1:0]  op1_r;
    logic                     op_last_r;
    logic                     pend_r;      // a captured term still awaits accumulation

    logic signed [2*width-1:0] prod_s;
    logic [acc_width-1:0]     prod_ext_s;
    logic [acc_width:0]       sum_s;

    logic [acc_width-1:0]     acc_r;
    logic [count_width-1:0]   count_r;
    logic                     ovf_r;
    logic                     in_ready_r;
    logic                     out_valid_r;

    signed_multiplier #(.width(width)) u_mult (
        .a       (op0_r),
        .b       (op1_r),
        .product (prod_s)
    );

    assign prod_ext_s = {{(acc_width-2*width){prod_s[2*width-1]}}, prod_s};
    assign sum_s      = sat_add(acc_r, prod_ext_s);

    // Next-state logic and transfer qualification
    always_comb begin
        state_next_s = state_r;
        xfer_s       = 1'b0;
        res_xfer_s   = 1'b0;
        case (state_r)
            IDLE, RUN: begin
                xfer_s = in_valid;
                if (in_valid) begin
                    if (last) begin
                        state_next_s = FLUSH;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            FLUSH: begin
                // The in-flight term must be the closing one; anything else is
                // an inconsistent state and the sum is dropped.
                if (pend_r && op_last_r) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                res_xfer_s = out_ready;
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and the handshake flags, decoded from the next state
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE) || (state_next_s == RUN);
            out_valid_r <= (state_next_s == HOLD);
        end
    end

    // Operand capture on each input transfer
    always_ff @(posedge clock) begin
        if (reset) begin
            op0_r     <= {width{1'b0}};
            op1_r     <= {width{1'b0}};
            op_last_r <= 1'b0;
            pend_r    <= 1'b0;
        end else if (xfer_s) begin
            op0_r     <= input0;
            op1_r     <= input1;
            op_last_r <= last;
            pend_r    <= 1'b1;
        end else begin
            pend_r    <= 1'b0;
        end
    end

    // Accumulator, term counter and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r   <= {acc_width{1'b0}};
            count_r <= {count_width{1'b0}};
            ovf_r   <= 1'b0;
        end else if (res_xfer_s) begin
            acc_r   <= {acc_width{1'b0}};
            count_r <= {count_width{1'b0}};
            ovf_r   <= 1'b0;
        end else if (pend_r) begin
            acc_r   <= sum_s[acc_width-1:0];
            ovf_r   <= ovf_r | sum_s[acc_width];
            if (count_r != count_max) begin
                count_r <= count_r + count_one;
            end else begin
                count_r <= count_r;
            end
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
            ovf_r   <= ovf_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = acc_r;
    assign count     = count_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator (width=8, acc_width=20, count_width=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each check sees the state left by the preceding edge.

module tb_mac_accumulator;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  input0;
    logic [7:0]  input1;
    logic        last;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] result;
    logic [7:0]  count;
    logic        overflow;

    int n_checks;
    int n_fail;

    mac_accumulator #(.width(8), .acc_width(20), .count_width(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input0    (input0),
        .input1    (input1),
        .last      (last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .count     (count),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic longint res_s();
        return longint'($signed(result));
    endfunction

    // One operand pair presented for exactly one cycle
    task automatic send(input int a, input int b, input logic l);
        in_valid = 1'b1;
        input0   = 8'(a);
        input1   = 8'(b);
        last     = l;
        step();
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic expect_out(input string tag, input longint r, input longint c, input longint o);
        check_val({tag, "_out_valid"}, out_valid, 1);
        check_val({tag, "_result"},    res_s(),   r);
        check_val({tag, "_count"},     count,     c);
        check_val({tag, "_overflow"},  overflow,  o);
        check_val({tag, "_in_ready"},  in_ready,  0);
    endtask

    task automatic take_result(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_val({tag, "_clr_out_valid"}, out_valid, 0);
        check_val({tag, "_clr_result"},    res_s(),   0);
        check_val({tag, "_clr_count"},     count,     0);
        check_val({tag, "_clr_overflow"},  overflow,  0);
        check_val({tag, "_clr_in_ready"},  in_ready,  1);
    endtask

    longint held_r, held_c, held_o;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        input0    = 8'd0;
        input1    = 8'd0;
        last      = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        check_val("rst_in_ready",  in_ready,  1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_result",    res_s(),   0);
        check_val("rst_count",     count,     0);
        check_val("rst_overflow",  overflow,  0);

        // Single term 3 * -4
        send(3, -4, 1'b1);
        check_val("single_flush_in_ready",  in_ready,  0);
        check_val("single_flush_out_valid", out_valid, 0);
        step();
        expect_out("single", -12, 1, 0);
        check_val("single_raw", result, 20'hFFFF4);
        take_result("single");

        // Four terms with bubbles in between
        send(5, 6, 1'b0);
        step();
        check_val("four_bubble_in_ready", in_ready, 1);
        step();
        send(-7, 2, 1'b0);
        step();
        send(127, 127, 1'b0);
        step();
        check_val("four_run_in_ready", in_ready, 1);
        check_val("four_run_partial", res_s(), 30 - 14 + 16129);
        send(-128, 1, 1'b1);
        check_val("four_flush_in_ready", in_ready, 0);
        step();
        expect_out("four", 16017, 4, 0);
        take_result("four");

        // Positive saturation, then backpressure in HOLD
        for (int i = 0; i < 33; i++) send(-128, -128, (i == 32));
        step();
        expect_out("possat", 524287, 33, 1);
        held_r = res_s();
        held_c = count;
        held_o = overflow;
        in_valid = 1'b1;
        input0   = 8'd9;
        input1   = 8'd9;
        last     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("bp_result",    res_s(),   524287);
            check_val("bp_count",     count,     33);
            check_val("bp_overflow",  overflow,  1);
            check_val("bp_in_ready",  in_ready,  0);
            check_val("bp_out_valid", out_valid, 1);
        end
        // out_ready and in_valid on the same edge: the pair must be ignored
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        last      = 1'b0;
        check_val("bp_rel_out_valid", out_valid, 0);
        check_val("bp_rel_result",    res_s(),   0);
        check_val("bp_rel_count",     count,     0);
        check_val("bp_rel_in_ready",  in_ready,  1);
        step();
        step();
        check_val("bp_ignored_count",  count,    0);
        check_val("bp_ignored_result", res_s(),  0);
        check_val("bp_ignored_ready",  in_ready, 1);

        // Negative saturation
        for (int i = 0; i < 33; i++) send(-128, 127, (i == 32));
        step();
        expect_out("negsat", -524288, 33, 1);
        take_result("negsat");

        // Reset in the middle of a sum
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("midrst_out_valid", out_valid, 0);
        check_val("midrst_result",    res_s(),   0);
        check_val("midrst_count",     count,     0);
        check_val("midrst_in_ready",  in_ready,  1);
        step();
        check_val("midrst_idle_result", res_s(), 0);
        send(2, 2, 1'b1);
        step();
        expect_out("midrst", 4, 1, 0);
        take_result("midrst");

        // Term counter saturates at 255
        for (int i = 0; i < 260; i++) send(1, 1, (i == 259));
        step();
        expect_out("cntsat", 260, 255, 0);
        take_result("cntsat");

        // Bounded wait guard: no result must appear without input
        for (int i = 0; i < 4; i++) step();
        check_val("quiet_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter width, default 8: operand width in bits, two's complement.
REQ-002 SHALL have parameter acc_width, default 2*width+4: accumulator width in bits, with 4 guard bits.
REQ-003 SHALL have parameter count_width, default 8: width of the term counter.
REQ-004 clock  input  1  rising-edge clock; the block has one clock only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 input0  input  width  signed multiplicand.
REQ-009 input1  input  width  signed multiplier.
REQ-010 last  input  1  qualified by in_valid; marks the final term of the sum.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  acc_width  signed saturated sum of products.
REQ-014 count  output  count_width  number of terms in result.
REQ-015 overflow  output  1  sticky flag: saturation occurred in this sum.

Function
REQ-016 Input transfer SHALL occur only on a rising edge where in_valid=1 and in_ready=1.
REQ-017 On each transfer, input0, input1 and last SHALL be captured into operand registers.
REQ-018 The product of the captured operands SHALL be formed by an instance of the team's signed multiplier, with the same width.
REQ-019 The product SHALL be 2*width bits signed and sign-extended to acc_width.
REQ-020 The sign-extended product SHALL be added into the accumulator on the edge following its transfer, so a term costs 1 cycle of latency.
REQ-021 The accumulator SHALL use signed saturating addition.
  - Sum > 2^(acc_width-1)-1: clamp to the maximum and set overflow=1.
  - Sum < -2^(acc_width-1): clamp to the minimum and set overflow=1.
REQ-022 Once set, overflow SHALL stay 1 until the result transfer.
REQ-023 count SHALL increment once per accumulated term and saturate at 2^count_width-1 without wrapping.
REQ-024 The FSM SHALL have four states: IDLE, RUN, FLUSH and HOLD.
REQ-025 IDLE behaviour:
  - accumulator=0, count=0, overflow=0, in_ready=1.
  - A transfer with last=0 goes to RUN.
  - A transfer with last=1 goes to FLUSH.
REQ-026 RUN behaviour:
  - in_ready=1.
  - A transfer with last=1 goes to FLUSH.
  - Cycles without in_valid (bubbles) SHALL NOT change the accumulator, apart from completing a term already in flight.
REQ-027 FLUSH behaviour:
  - in_ready=0.
  - Lasts exactly 1 cycle, during which the last term is accumulated.
  - Then goes to HOLD.
REQ-028 HOLD behaviour:
  - out_valid=1 and in_ready=0.
  - result, count and overflow SHALL stay stable until out_ready=1.
REQ-029 A result transfer (out_valid=1 and out_ready=1) SHALL take HOLD to IDLE and clear the accumulator, count and overflow on the same edge.
REQ-030 out_valid SHALL rise on edge N+1 after the last term transfers on edge N.
REQ-031 out_valid SHALL be 0 in every state other than HOLD.
REQ-032 out_ready SHALL be ignored outside HOLD.
REQ-033 Simultaneous events:
  - in_valid has no effect in HOLD, even when out_ready=1 on the same edge.
  - The next sum starts only in IDLE.
REQ-034 result SHALL be a direct register output with no combinational path from any input.
REQ-035 in_ready SHALL be derived from the state only.

Reset
REQ-036 While reset=1 on an edge, the block SHALL go to IDLE.
REQ-037 After reset: in_ready=1, out_valid=0, result=0, count=0, overflow=0.
REQ-038 Reset SHALL take priority over all transfers.
REQ-039 A sum in progress (RUN, FLUSH or HOLD) SHALL be discarded on reset with no partial result emitted.
REQ-040 Operand registers SHALL clear to 0 on reset.

Verification
REQ-041 Single term: input0=3, input1=-4, last=1 at edge N -> out_valid=1 after edge N+1, result=-12 (0xFFFF4), count=1, overflow=0.
REQ-042 Four terms with bubbles between them (5*6, -7*2, 127*127, -128*1, last on the 4th) -> result=16017, count=4, overflow=0; in_ready=0 exactly in FLUSH and HOLD.
REQ-043 Saturation: 33 terms of -128*-128 -> result=524287, overflow=1, count=33.
REQ-044 Negative saturation: 33 terms of -128*127 -> result=-524288, overflow=1.
REQ-045 Backpressure: out_ready=0 for 5 cycles in HOLD -> result, count and overflow stable, in_ready=0, in_valid ignored; out_ready=1 -> IDLE with all outputs cleared on the next cycle.
REQ-046 Reset mid-sum: reset asserted after 2 of 4 terms, then a fresh single term 2*2 with last=1 -> result=4, count=1.
